// File: rtl/maze_pkg.sv
// Shared encodings and heading arithmetic for the wall-follower maze solver.
package maze_pkg;

  localparam logic [1:0] EAST  = 2'd0;
  localparam logic [1:0] NORTH = 2'd1;
  localparam logic [1:0] WEST  = 2'd2;
  localparam logic [1:0] SOUTH = 2'd3;

  localparam logic HAND_RIGHT = 1'b0;
  localparam logic HAND_LEFT  = 1'b1;

  typedef enum logic [2:0] {IDLE, MARK, PROBE, EVAL, MOVE, FIN} state_t;

  // Probe k of the wall-follower: turn toward the followed wall first, then
  // straight, then away from it, finally back the way we came.
  function automatic logic [1:0] probe_dir(input logic [1:0] heading,
                                           input logic       hand,
                                           input logic [1:0] k);
    logic [1:0] turn;
    case (k)
      2'd0:    turn = (hand == HAND_LEFT) ? 2'd1 : 2'd3;
      2'd1:    turn = 2'd0;
      2'd2:    turn = (hand == HAND_LEFT) ? 2'd3 : 2'd1;
      default: turn = 2'd2;
    endcase
    return heading + turn;
  endfunction

endpackage

// File: rtl/maze_nbr_calc.sv
// Neighbour cell of {row,col} in direction dir, with an out-of-bounds flag.
module maze_nbr_calc
  import maze_pkg::*;
#(
  parameter int ROWS = 64,
  parameter int COLS = 64,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
) (
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  input  logic [1:0]    dir,
  output logic [RW-1:0] nbr_row,
  output logic [CW-1:0] nbr_col,
  output logic          oob
);

  logic [RW:0] r_ext;
  logic [CW:0] c_ext;

  // The extra bit turns an underflow into a value >= the limit, so a single
  // magnitude compare covers both edges.
  always_comb begin
    r_ext = {1'b0, row};
    c_ext = {1'b0, col};
    case (dir)
      EAST:    c_ext = c_ext + (CW+1)'(1);
      NORTH:   r_ext = r_ext - (RW+1)'(1);
      WEST:    c_ext = c_ext - (CW+1)'(1);
      default: r_ext = r_ext + (RW+1)'(1);
    endcase
    oob     = (r_ext >= (RW+1)'(ROWS)) || (c_ext >= (CW+1)'(COLS));
    nbr_row = r_ext[RW-1:0];
    nbr_col = c_ext[CW-1:0];
  end

endmodule

// File: rtl/maze_walker.sv
// Clocked right/left-hand wall-follower walking an external ROWS x COLS bitmap.
module maze_walker
  import maze_pkg::*;
#(
  parameter int ROWS      = 64,
  parameter int COLS      = 64,
  parameter int RW        = $clog2(ROWS),
  parameter int CW        = $clog2(COLS),
  parameter int MAX_STEPS = 4096,
  parameter int SW        = $clog2(MAX_STEPS+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] start_row,
  input  logic [CW-1:0] start_col,
  input  logic [1:0]    start_dir,
  input  logic          hand_sel,
  input  logic          maze_in,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          maze_oe,
  output logic          maze_we,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [SW-1:0] step_count
);

  state_t        state, state_nx;
  logic [RW-1:0] cur_row, start_row_q, nbr_row;
  logic [CW-1:0] cur_col, start_col_q, nbr_col;
  logic [1:0]    heading, k, p;
  logic          hand, oob, accept, on_border, at_start, limit_hit;
  logic          done_set, fail_set;

  assign p = probe_dir(heading, hand, k);

  maze_nbr_calc #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) u_nbr (
    .row     (cur_row),
    .col     (cur_col),
    .dir     (p),
    .nbr_row (nbr_row),
    .nbr_col (nbr_col),
    .oob     (oob)
  );

  assign busy      = state inside {MARK, PROBE, EVAL, MOVE};
  assign accept    = start && !busy;
  assign on_border = (nbr_row == '0) || (nbr_row == RW'(ROWS-1)) ||
                     (nbr_col == '0) || (nbr_col == CW'(COLS-1));
  assign at_start  = (nbr_row == start_row_q) && (nbr_col == start_col_q);
  assign limit_hit = (step_count == SW'(MAX_STEPS-1));

  always_comb begin
    state_nx = state;
    row      = '0;
    col      = '0;
    maze_oe  = 1'b0;
    maze_we  = 1'b0;
    done_set = 1'b0;
    fail_set = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = MARK;
      MARK: begin
        row      = cur_row;
        col      = cur_col;
        maze_we  = 1'b1;
        state_nx = PROBE;
      end
      PROBE: begin
        if (oob) begin
          if (k == 2'd3) begin
            fail_set = 1'b1;
            state_nx = FIN;
          end
        end else begin
          row      = nbr_row;
          col      = nbr_col;
          maze_oe  = 1'b1;
          state_nx = EVAL;
        end
      end
      EVAL: begin
        row = nbr_row;
        col = nbr_col;
        if (!maze_in) state_nx = MOVE;
        else if (k == 2'd3) begin
          fail_set = 1'b1;
          state_nx = FIN;
        end else state_nx = PROBE;
      end
      MOVE: begin
        row     = nbr_row;
        col     = nbr_col;
        maze_we = 1'b1;
        if (on_border && !at_start) begin
          done_set = 1'b1;
          state_nx = FIN;
        end else if (limit_hit) begin
          fail_set = 1'b1;
          state_nx = FIN;
        end else state_nx = PROBE;
      end
      FIN:     state_nx = accept ? MARK : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_row     <= '0;
      cur_col     <= '0;
      start_row_q <= '0;
      start_col_q <= '0;
      heading     <= EAST;
      hand        <= HAND_RIGHT;
      k           <= '0;
      done        <= 1'b0;
      fail        <= 1'b0;
      step_count  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cur_row     <= start_row;
        cur_col     <= start_col;
        start_row_q <= start_row;
        start_col_q <= start_col;
        heading     <= start_dir;
        hand        <= hand_sel;
        k           <= '0;
        done        <= 1'b0;
        fail        <= 1'b0;
        step_count  <= '0;
      end
      if (done_set) done <= 1'b1;
      if (fail_set) fail <= 1'b1;
      case (state)
        MARK:  k <= '0;
        PROBE: if (oob) k <= k + 2'd1;
        EVAL:  if (maze_in) k <= k + 2'd1;
        MOVE: begin
          cur_row <= nbr_row;
          cur_col <= nbr_col;
          heading <= p;
          k       <= '0;
          if (step_count != SW'(MAX_STEPS)) step_count <= step_count + SW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/maze_walker.md
Name: maze_walker

Overview:
- Parametrised, fully clocked wall-follower maze solver, successor to the fixed 64x64 right-hand solver.
- Walks a ROWS x COLS bitmap held in external single-port cell memory (1 = wall, 0 = free) and marks each visited cell by writing it.
- Adds over the previous generation:
  - selectable right-hand or left-hand rule
  - start/busy handshake and restart without reset
  - out-of-bounds guarding
  - step counter
  - failure reporting for enclosed starts and step-limit overrun

Parameters:
- ROWS, 64, maze height in cells (>=2).
- COLS, 64, maze width in cells (>=2).
- RW, $clog2(ROWS), row address width.
- CW, $clog2(COLS), column address width.
- MAX_STEPS, 4096, move limit before fail.
- SW, $clog2(MAX_STEPS+1), step counter width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only when busy=0.
- start_row  in  RW  starting row, sampled on accepted start.
- start_col  in  CW  starting column, sampled on accepted start.
- start_dir  in  2  initial heading: 0 east (col+1), 1 north (row-1), 2 west (col-1), 3 south (row+1).
- hand_sel  in  1  0 right-hand rule, 1 left-hand rule; sampled on accepted start.
- maze_in  in  1  cell value at {row,col}; valid the cycle after maze_oe=1.
- row  out  RW  memory row address.
- col  out  CW  memory column address.
- maze_oe  out  1  read enable.
- maze_we  out  1  write enable (mark visited cell).
- busy  out  1  walk in progress.
- done  out  1  exit reached; held until the next accepted start.
- fail  out  1  enclosed start or step limit reached; held until the next accepted start.
- step_count  out  SW  moves made since start.

Behaviour:
- Reset values: all outputs 0; internal state IDLE, heading 0, probe index 0.
- Sampled inputs are captured into registers; the block never relies on external inputs holding after start.
- States: IDLE, MARK, PROBE, EVAL, MOVE, FIN.
- IDLE:
  - maze_oe=0, maze_we=0.
  - On start: capture inputs, clear done/fail/step_count, set busy=1, go to MARK.
  - start while busy=1 is ignored.
- MARK (1 cycle): drive start cell address with maze_we=1, probe index=0, go to PROBE.
- Probe order by probe index k=0..3:
  - right-hand: heading-1, heading, heading+1, heading+2 (mod 4).
  - left-hand: heading+1, heading, heading-1, heading+2 (mod 4).
- PROBE (1 cycle):
  - Compute the neighbour cell in probe direction p.
  - If it leaves 0..ROWS-1 / 0..COLS-1: treat as wall, no memory access. Increment k (k=3 -> FIN with fail=1), stay in PROBE.
  - Otherwise drive row/col=neighbour with maze_oe=1, go to EVAL.
- EVAL (1 cycle):
  - Sample maze_in. Address holds; oe=0.
  - If maze_in=1: k++ and go to PROBE. If k was 3, go to FIN with fail=1.
  - If maze_in=0: go to MOVE.
- MOVE (1 cycle):
  - current cell=neighbour, heading=p, maze_we=1 at new cell, step_count++, k=0.
  - If the new cell is on the border (row 0, row ROWS-1, col 0, col COLS-1) and differs from the start cell: FIN with done=1.
  - Else if step_count reaches MAX_STEPS: FIN with fail=1.
  - Else go to PROBE.
- FIN: busy=0, oe=we=0, flag held; go to IDLE the same cycle.
- Latency:
  - 2 cycles per in-range probe, 1 per out-of-range probe, 1 per move.
  - done/fail rise in the cycle after the deciding MOVE/EVAL/PROBE edge.
- Invariants:
  - maze_oe and maze_we are never both 1.
  - done and fail are mutually exclusive.
- Reset mid-walk returns immediately to reset values; memory contents are untouched.
- Arithmetic: coordinates are computed with one extra bit to detect underflow/overflow. Heading wraps mod 4. step_count saturates at MAX_STEPS.

Decomposition:
- Package maze_pkg:
  - heading encoding constants (EAST/NORTH/WEST/SOUTH)
  - state enum
  - hand_sel encoding
  - function for heading rotation
- One sub-module, maze_nbr_calc (combinational): takes row, col, direction and returns neighbour row/col plus an out-of-bounds flag.

Test Plan:
- 4x4 maze, walls everywhere except (1,1),(1,2),(0,2); start (1,1) east, right-hand -> done=1 at cell (0,2), step_count=2, we pulses at (1,1),(1,2),(0,2).
- Same start cell fully walled (4 neighbours=1) -> fail=1 after 8 probe cycles, step_count=0, done=0.
- Corridor maze, MAX_STEPS=5, no exit within 5 moves -> fail=1, step_count=5.
- Symmetric T-junction maze: right-hand exits right branch at (0,3); left-hand exits left branch at (0,0).
- Start on border (0,1) heading south -> no immediate done; out-of-range north probe issues no maze_oe pulse.
- Assert rst during EVAL -> all outputs 0 next cycle; start accepted afterwards. Start pulsed while busy=1 -> ignored.
